// File: rtl/hot_pfn_filter_fifo_if.sv
// PFN stream bundle: raw tracker strobe in, filtered FIFO head out toward hot_addr_push.
// Handshake: the tracker side is a bare strobe (trk_pfn_valid, no ready, never stalled);
//   the migration side pops the head on any cycle where page_mig_addr_en & page_mig_addr_ready,
//   and en/addr hold stable until that pop. Ready may be high while en is low.
interface hot_pfn_filter_fifo_if #(
   parameter int ADDR_SIZE = 33
);
   logic                 trk_pfn_valid;
   logic [ADDR_SIZE-1:0] trk_pfn;
   logic                 page_mig_addr_en;
   logic [ADDR_SIZE-1:0] page_mig_addr;
   logic                 page_mig_addr_ready;

   modport slave (
      input  trk_pfn_valid, trk_pfn, page_mig_addr_ready,
      output page_mig_addr_en, page_mig_addr
   );

   modport master (
      output trk_pfn_valid, trk_pfn, page_mig_addr_ready,
      input  page_mig_addr_en, page_mig_addr
   );
endinterface

// File: rtl/hot_pfn_filter_fifo.sv
// Filters tracker PFNs (range/sentinel, recent-history dedup, overflow) and buffers the
// survivors in a FIFO whose head is held in a register for hot_addr_push.
module hot_pfn_filter_fifo #(
   parameter int ADDR_SIZE   = 33,
   parameter int FIFO_DEPTH  = 32,
   parameter int DEDUP_DEPTH = 16
) (
   input  logic                          axi4_mm_clk,
   input  logic                          axi4_mm_rst_n,
   hot_pfn_filter_fifo_if.slave          bus,
   input  logic [32:0]                   csr_addr_lb,
   input  logic [32:0]                   csr_addr_ub,
   input  logic                          csr_dedup_flush,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [31:0]                   drop_range_cnt,
   output logic [31:0]                   drop_dup_cnt,
   output logic [31:0]                   drop_full_cnt
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam int HW = (DEDUP_DEPTH > 1) ? $clog2(DEDUP_DEPTH) : 1;

   logic                 s0_vld;
   logic [ADDR_SIZE-1:0] s0_pfn;

   logic [ADDR_SIZE-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr, rd_ptr, wr_next, rd_next;
   logic [ADDR_SIZE-1:0] head_q, head_next;

   logic [DEDUP_DEPTH-1:0] hist_vld;
   logic [ADDR_SIZE-1:0]   hist_pfn [DEDUP_DEPTH];
   logic [HW-1:0]          rr_ptr;

   logic [32:0] pfn_ext;
   logic        out_of_range, dup_hit, full, pop, push;
   logic        drop_range, drop_dup, drop_full;

   always_comb begin
      pfn_ext      = 33'(s0_pfn);
      out_of_range = (s0_pfn == '1) || (pfn_ext < csr_addr_lb) || (pfn_ext > csr_addr_ub);
      dup_hit      = 1'b0;
      for (int i = 0; i < DEDUP_DEPTH; i++) begin
         if (hist_vld[i] && (hist_pfn[i] == s0_pfn)) dup_hit = 1'b1;
      end
   end

   assign fifo_level           = wr_ptr - rd_ptr;
   assign full                 = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign bus.page_mig_addr_en = (fifo_level != '0);
   assign bus.page_mig_addr    = head_q;
   assign pop                  = bus.page_mig_addr_en & bus.page_mig_addr_ready;

   // Priority: range beats dup beats full; a pop in the same cycle frees the slot.
   assign drop_range = s0_vld & out_of_range;
   assign drop_dup   = s0_vld & ~out_of_range & dup_hit;
   assign drop_full  = s0_vld & ~out_of_range & ~dup_hit & full & ~pop;
   assign push       = s0_vld & ~out_of_range & ~dup_hit & (~full | pop);

   assign wr_next = wr_ptr + PW'(push);
   assign rd_next = rd_ptr + PW'(pop);

   // Next head comes from the write port when the slot being pushed becomes the head.
   always_comb begin
      head_next = mem[rd_next[AW-1:0]];
      if (wr_next == rd_next)             head_next = '1;
      else if (push && (wr_ptr == rd_next)) head_next = s0_pfn;
   end

   always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
      if (!axi4_mm_rst_n) begin
         s0_vld         <= 1'b0;
         s0_pfn         <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         head_q         <= '1;
         hist_vld       <= '0;
         rr_ptr         <= '0;
         drop_range_cnt <= '0;
         drop_dup_cnt   <= '0;
         drop_full_cnt  <= '0;
      end else begin
         s0_vld <= bus.trk_pfn_valid;
         s0_pfn <= bus.trk_pfn;
         wr_ptr <= wr_next;
         rd_ptr <= rd_next;
         head_q <= head_next;
         // Later assignment wins, so an insert in a flush cycle survives.
         if (csr_dedup_flush) hist_vld <= '0;
         if (push) begin
            hist_vld[rr_ptr] <= 1'b1;
            rr_ptr <= (rr_ptr == HW'(DEDUP_DEPTH - 1)) ? '0 : rr_ptr + HW'(1);
         end
         if (drop_range && (drop_range_cnt != '1)) drop_range_cnt <= drop_range_cnt + 32'd1;
         if (drop_dup   && (drop_dup_cnt   != '1)) drop_dup_cnt   <= drop_dup_cnt + 32'd1;
         if (drop_full  && (drop_full_cnt  != '1)) drop_full_cnt  <= drop_full_cnt + 32'd1;
      end
   end

   always_ff @(posedge axi4_mm_clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= s0_pfn;
         hist_pfn[rr_ptr]    <= s0_pfn;
      end
   end
endmodule

// File: tb/tb_hot_pfn_filter_fifo.sv
// Bench for hot_pfn_filter_fifo: directed scenarios plus random traffic, all checked
// against a queue-based model of the filter rules and FIFO contents.
module tb_hot_pfn_filter_fifo;
   localparam int ADDR_SIZE   = 33;
   localparam int FIFO_DEPTH  = 32;
   localparam int DEDUP_DEPTH = 16;
   localparam int LW          = $clog2(FIFO_DEPTH) + 1;

   // clock / reset
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [32:0]   lb, ub;
   logic          csr_dedup_flush;
   logic [LW-1:0] fifo_level;
   logic [31:0]   drop_range_cnt, drop_dup_cnt, drop_full_cnt;

   hot_pfn_filter_fifo_if #(.ADDR_SIZE(ADDR_SIZE)) bus ();

   hot_pfn_filter_fifo #(
      .ADDR_SIZE(ADDR_SIZE), .FIFO_DEPTH(FIFO_DEPTH), .DEDUP_DEPTH(DEDUP_DEPTH)
   ) dut (
      .axi4_mm_clk     (clk),
      .axi4_mm_rst_n   (rst_n),
      .bus             (bus),
      .csr_addr_lb     (lb),
      .csr_addr_ub     (ub),
      .csr_dedup_flush (csr_dedup_flush),
      .fifo_level      (fifo_level),
      .drop_range_cnt  (drop_range_cnt),
      .drop_dup_cnt    (drop_dup_cnt),
      .drop_full_cnt   (drop_full_cnt)
   );

   // scoreboard / reference model
   logic [ADDR_SIZE-1:0] exp_q[$];
   logic [ADDR_SIZE-1:0] hist_q[$];   // newest first
   int                   hist_live;   // how many of the newest entries are still valid
   int                   m_range, m_dup, m_full;
   logic                 m_s0_vld;
   logic [ADDR_SIZE-1:0] m_s0_pfn;
   logic [ADDR_SIZE-1:0] ones;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic bit seen_recently(input logic [ADDR_SIZE-1:0] pfn);
      for (int i = 0; i < hist_live; i++) if (hist_q[i] == pfn) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      hist_q.delete();
      hist_live = 0;
      m_range   = 0;
      m_dup     = 0;
      m_full    = 0;
      m_s0_vld  = 1'b0;
      m_s0_pfn  = '0;
   endtask

   task automatic model_edge(input logic vld, input logic [ADDR_SIZE-1:0] pfn,
                             input logic rdy, input logic flsh);
      bit pop_now, push_now;
      pop_now  = (exp_q.size() != 0) && rdy;
      push_now = 1'b0;
      if (m_s0_vld) begin
         if (m_s0_pfn == ones || m_s0_pfn < lb || m_s0_pfn > ub) m_range++;
         else if (seen_recently(m_s0_pfn))                       m_dup++;
         else if (exp_q.size() == FIFO_DEPTH && !pop_now)        m_full++;
         else                                                    push_now = 1'b1;
      end
      if (flsh) hist_live = 0;
      if (pop_now) void'(exp_q.pop_front());
      if (push_now) begin
         exp_q.push_back(m_s0_pfn);
         hist_q.push_front(m_s0_pfn);
         if (hist_q.size() > DEDUP_DEPTH) void'(hist_q.pop_back());
         if (hist_live < DEDUP_DEPTH) hist_live++;
      end
      m_s0_vld = vld;
      m_s0_pfn = pfn;
   endtask

   task automatic compare_all(input string ph);
      logic [ADDR_SIZE-1:0] ea;
      ea = (exp_q.size() != 0) ? exp_q[0] : ones;
      check({ph, "_en"},    64'(bus.page_mig_addr_en), 64'(exp_q.size() != 0));
      check({ph, "_addr"},  64'(bus.page_mig_addr),    64'(ea));
      check({ph, "_level"}, 64'(fifo_level),           64'(exp_q.size()));
      check({ph, "_rng"},   64'(drop_range_cnt),       64'(m_range));
      check({ph, "_dup"},   64'(drop_dup_cnt),         64'(m_dup));
      check({ph, "_full"},  64'(drop_full_cnt),        64'(m_full));
   endtask

   // driver: inputs change 1 time unit after a rising edge, outputs sampled there too
   task automatic tick(input string ph, input logic vld, input logic [ADDR_SIZE-1:0] pfn,
                       input logic rdy, input logic flsh);
      bus.trk_pfn_valid       = vld;
      bus.trk_pfn             = pfn;
      bus.page_mig_addr_ready = rdy;
      csr_dedup_flush         = flsh;
      @(posedge clk);
      model_edge(vld, pfn, rdy, flsh);
      #1;
      compare_all(ph);
   endtask

   task automatic idle(input string ph, input int n, input logic rdy);
      for (int i = 0; i < n; i++) tick(ph, 1'b0, '0, rdy, 1'b0);
   endtask

   initial begin
      logic [ADDR_SIZE-1:0] p;
      int bias, sel;
      ones = '1;
      model_reset();
      lb = 33'h100;
      ub = 33'h1FF;
      bus.trk_pfn_valid       = 1'b0;
      bus.trk_pfn             = '0;
      bus.page_mig_addr_ready = 1'b0;
      csr_dedup_flush         = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      compare_all("reset");
      rst_n = 1'b1;

      // T1: two-edge latency, head stable while ready is low
      tick("t1", 1'b1, 33'h150, 1'b0, 1'b0);
      check("t1_en_early", 64'(bus.page_mig_addr_en), 64'd0);
      tick("t1", 1'b0, '0, 1'b0, 1'b0);
      check("t1_en", 64'(bus.page_mig_addr_en), 64'd1);
      check("t1_addr", 64'(bus.page_mig_addr), 64'h150);
      for (int i = 0; i < 5; i++) begin
         tick("t1_hold", 1'b0, '0, 1'b0, 1'b0);
         check("t1_stable", 64'(bus.page_mig_addr), 64'h150);
      end
      idle("t1_drain", 2, 1'b1);

      // T2: below, above and sentinel all drop as range
      tick("t2", 1'b1, 33'h0FF, 1'b1, 1'b0);
      tick("t2", 1'b1, 33'h200, 1'b1, 1'b0);
      tick("t2", 1'b1, ones,    1'b1, 1'b0);
      idle("t2", 2, 1'b1);
      check("t2_rng", 64'(drop_range_cnt), 64'd3);
      check("t2_en", 64'(bus.page_mig_addr_en), 64'd0);
      check("t2_addr", 64'(bus.page_mig_addr), 64'(ones));

      // T3: back-to-back duplicate, then flush re-enables the PFN
      tick("t3", 1'b0, '0, 1'b0, 1'b1);
      tick("t3", 1'b1, 33'h150, 1'b0, 1'b0);
      tick("t3", 1'b1, 33'h150, 1'b0, 1'b0);
      idle("t3", 2, 1'b0);
      check("t3_level", 64'(fifo_level), 64'd1);
      check("t3_dup", 64'(drop_dup_cnt), 64'd1);
      idle("t3_drain", 1, 1'b1);
      tick("t3", 1'b0, '0, 1'b0, 1'b1);
      tick("t3", 1'b1, 33'h150, 1'b0, 1'b0);
      idle("t3", 2, 1'b0);
      check("t3_reaccept", 64'(fifo_level), 64'd1);
      idle("t3_drain", 2, 1'b1);

      // T4: overfill with ready low
      for (int i = 0; i < 34; i++) tick("t4", 1'b1, ADDR_SIZE'(33'h160 + i), 1'b0, 1'b0);
      idle("t4", 2, 1'b0);
      check("t4_level", 64'(fifo_level), 64'd32);
      check("t4_full", 64'(drop_full_cnt), 64'd2);

      // T5: push into a full FIFO on a pop cycle is accepted
      tick("t5", 1'b1, 33'h1F0, 1'b0, 1'b0);
      tick("t5", 1'b0, '0, 1'b1, 1'b0);
      check("t5_level", 64'(fifo_level), 64'd32);
      check("t5_full", 64'(drop_full_cnt), 64'd2);
      idle("t4_drain", 33, 1'b1);
      check("t4_empty", 64'(fifo_level), 64'd0);

      // random traffic
      for (int seg = 0; seg < 8; seg++) begin
         bias = (seg % 3 == 0) ? 20 : ((seg % 3 == 1) ? 55 : 90);
         if (seg == 5) begin
            lb = 33'h1C0;
            ub = 33'h120;
         end else begin
            lb = 33'(ADDR_SIZE'($urandom_range(32'h0F0, 32'h140)));
            ub = 33'(ADDR_SIZE'($urandom_range(32'h1A0, 32'h210)));
         end
         for (int i = 0; i < 250; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      p = ones;
            else if (sel < 4)  p = ADDR_SIZE'(32'h170 + $urandom_range(0, 15));
            else               p = ADDR_SIZE'($urandom_range(32'h0E0, 32'h220));
            tick("rnd", 1'($urandom_range(0, 3) != 0), p,
                 1'($urandom_range(0, 99) < bias), 1'($urandom_range(0, 63) == 0));
         end
      end

      // T6: asynchronous reset with a partly filled FIFO
      lb = 33'h100;
      ub = 33'h1FF;
      idle("t6_drain", 40, 1'b1);
      tick("t6", 1'b0, '0, 1'b0, 1'b1);
      for (int i = 1; i <= 5; i++) tick("t6", 1'b1, ADDR_SIZE'(33'h100 + i), 1'b0, 1'b0);
      idle("t6", 2, 1'b0);
      check("t6_level5", 64'(fifo_level), 64'd5);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("t6_en", 64'(bus.page_mig_addr_en), 64'd0);
      check("t6_addr", 64'(bus.page_mig_addr), 64'(ones));
      check("t6_level", 64'(fifo_level), 64'd0);
      check("t6_rng", 64'(drop_range_cnt), 64'd0);
      check("t6_dup", 64'(drop_dup_cnt), 64'd0);
      check("t6_full", 64'(drop_full_cnt), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle("t6_post", 2, 1'b1);
      tick("t6_post", 1'b1, 33'h105, 1'b0, 1'b0);
      idle("t6_post", 3, 1'b0);
      idle("t6_post", 2, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
